// File: rtl/sample_link_pkg.sv
// Shared definitions for the sample serial link (transmitter and receiver).
// Holds the state encoding, the default word width and a counter-width helper.
package sample_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } link_state_t;

    localparam int DEF_DATA_W = 12;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_serial_tx_bit_tick.sv
// Bit-period prescaler: pulses tick on the last clk of every CLK_DIV-cycle period.
// Ports: clk, reset (sync, active-high), clear (restart period), tick (1-cycle pulse).
module tx_bit_tick
    import sample_link_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        if (clear || tick) div_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/sample_serial_tx.sv
// Parallel-to-serial sample transmitter: MSB first, optional even parity, idle gap.
// Ports: clk, reset (sync, active-high), in_data/in_valid/in_ready (handshake),
//        sdo (serial data), sframe (data/parity active), busy, word_count (frames sent).
module sample_serial_tx
    import sample_link_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CLK_DIV    = 1,
    parameter int PARITY_EN  = 1,
    parameter int GAP_CYCLES = 2,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               sdo,
    output logic               sframe,
    output logic               busy,
    output logic [COUNT_W-1:0] word_count
);

    localparam int BIT_W = clog2(DATA_W + 1);
    localparam int GAP_W = clog2(GAP_CYCLES + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    link_state_t        state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               par_q, par_d;
    logic               sdo_q, sdo_d;
    logic               sframe_q, sframe_d;
    logic               rdy_q, rdy_d;
    logic [COUNT_W-1:0] wcnt_q, wcnt_d;
    logic               accept;
    logic               tick;
    logic               enter_tail;

    // in_ready is only ever high in IDLE, so it alone qualifies the accept.
    assign accept = in_valid & rdy_q;

    tx_bit_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        par_d      = par_q;
        sdo_d      = sdo_q;
        sframe_d   = sframe_q;
        rdy_d      = rdy_q;
        wcnt_d     = wcnt_q;
        enter_tail = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d  = in_data;
                    par_d    = 1'b0;
                    bit_d    = '0;
                    sdo_d    = in_data[DATA_W-1];
                    sframe_d = 1'b1;
                    rdy_d    = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    // Bit currently on the line sits in the shift reg MSB.
                    par_d = par_q ^ shreg_q[DATA_W-1];
                    if (bit_q == BIT_LAST) begin
                        wcnt_d = wcnt_q + 1'b1;
                        if (PARITY_EN != 0) begin
                            sdo_d   = par_q ^ shreg_q[DATA_W-1];
                            state_d = ST_PARITY;
                        end else begin
                            enter_tail = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                        sdo_d   = shreg_q[DATA_W-2];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) enter_tail = 1'b1;
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        rdy_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
        endcase

        // Frame body finished: drop the line and go to the gap or straight to idle.
        if (enter_tail) begin
            sdo_d    = 1'b0;
            sframe_d = 1'b0;
            gap_d    = '0;
            if (GAP_CYCLES > 0) begin
                state_d = ST_GAP;
            end else begin
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            par_q    <= 1'b0;
            sdo_q    <= 1'b0;
            sframe_q <= 1'b0;
            rdy_q    <= 1'b1;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            par_q    <= par_d;
            sdo_q    <= sdo_d;
            sframe_q <= sframe_d;
            rdy_q    <= rdy_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign in_ready   = rdy_q;
    assign sdo        = sdo_q;
    assign sframe     = sframe_q;
    assign busy       = (state_q != ST_IDLE);
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_sample_serial_tx.sv
// Bench for sample_serial_tx: three instances (A, B, A with 4-bit counter),
// serial bits checked against a scoreboard queue filled at each accept.
module tb_sample_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] in_data  [3];
    logic        in_valid [3];
    logic        in_ready [3];
    logic        sdo      [3];
    logic        sframe   [3];
    logic        busy     [3];
    logic [15:0] wc_a;
    logic [15:0] wc_b;
    logic [3:0]  wc_c;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    bit q [3][$];

    sample_serial_tx #(
        .DATA_W(12), .CLK_DIV(1), .PARITY_EN(1),
        .GAP_CYCLES(2), .COUNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset),
        .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .sdo(sdo[0]), .sframe(sframe[0]),
        .busy(busy[0]), .word_count(wc_a)
    );

    sample_serial_tx #(
        .DATA_W(12), .CLK_DIV(4), .PARITY_EN(0),
        .GAP_CYCLES(0), .COUNT_W(16)
    ) dut_b (
        .clk(clk), .reset(reset),
        .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .sdo(sdo[1]), .sframe(sframe[1]),
        .busy(busy[1]), .word_count(wc_b)
    );

    sample_serial_tx #(
        .DATA_W(12), .CLK_DIV(1), .PARITY_EN(1),
        .GAP_CYCLES(2), .COUNT_W(4)
    ) dut_c (
        .clk(clk), .reset(reset),
        .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .sdo(sdo[2]), .sframe(sframe[2]),
        .busy(busy[2]), .word_count(wc_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wc(input int d);
        case (d)
            0:       return 32'(wc_a);
            1:       return 32'(wc_b);
            default: return 32'(wc_c);
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Expected line contents: each bit held for CLK_DIV cycles, then parity.
    task automatic push_word(input int d, input logic [11:0] w);
        int div;
        div = (d == 1) ? 4 : 1;
        for (int i = 11; i >= 0; i--) begin
            repeat (div) q[d].push_back(w[i]);
        end
        if (d != 1) q[d].push_back(^w);
    endtask

    task automatic send(input int d, input logic [11:0] w);
        in_data[d]  = w;
        in_valid[d] = 1'b1;
        push_word(d, w);
    endtask

    task automatic wait_ready(input int d, output int n);
        n = 1;
        while (in_ready[d] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (sframe[d] === 1'b1) begin
                    chk($sformatf("sb_pending%0d", d),
                        32'(q[d].size() != 0), 32'd1);
                    if (q[d].size() != 0)
                        chk($sformatf("sb_bit%0d", d),
                            32'(sdo[d]), 32'(q[d].pop_front()));
                end else begin
                    chk($sformatf("idle_sdo%0d", d), 32'(sdo[d]), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [3:0] exp_wc;

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_data[d]  = '0;
            in_valid[d] = 1'b0;
        end
        repeat (3) step();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle after reset: quiet line, ready, nothing counted.
        for (int c = 0; c < 20; c++) begin
            for (int d = 0; d < 3; d++) begin
                chk("rst_sframe", 32'(sframe[d]), 32'd0);
                chk("rst_busy", 32'(busy[d]), 32'd0);
                chk("rst_ready", 32'(in_ready[d]), 32'd1);
                chk("rst_wc", wc(d), 32'd0);
            end
            step();
        end

        // Single frame 0xA5C on A: timing of sframe, busy, ready, count.
        send(0, 12'hA5C);
        step();
        in_valid[0] = 1'b0;
        for (int c = 1; c < 16; c++) begin
            chk("t1_sframe", 32'(sframe[0]), 32'(c <= 13));
            chk("t1_busy", 32'(busy[0]), 32'd1);
            chk("t1_ready", 32'(in_ready[0]), 32'd0);
            if (c == 12) chk("t1_wc_before", wc(0), 32'd0);
            if (c == 13) chk("t1_wc_after", wc(0), 32'd1);
            step();
        end
        chk("t1_ready16", 32'(in_ready[0]), 32'd1);
        chk("t1_busy16", 32'(busy[0]), 32'd0);
        chk("t1_wc16", wc(0), 32'd1);

        // Back-to-back with in_valid held; in_data churn while not ready.
        send(0, 12'hFFF);
        step();
        for (int c = 1; c < 16; c++) begin
            if (c == 1) in_data[0] = 12'h3C3;
            if (c == 8) begin
                in_data[0] = 12'h001;
                push_word(0, 12'h001);
            end
            chk("t2_ready_low", 32'(in_ready[0]), 32'd0);
            step();
        end
        chk("t2_ready16", 32'(in_ready[0]), 32'd1);
        step();
        in_valid[0] = 1'b0;
        chk("t2_busy2", 32'(busy[0]), 32'd1);
        wait_ready(0, n);
        chk("t2_period", 32'(n), 32'd16);
        chk("t2_wc", wc(0), 32'd3);

        // B: CLK_DIV=4, no parity, no gap.
        send(1, 12'h800);
        step();
        in_valid[1] = 1'b0;
        wait_ready(1, n);
        chk("t3_period", 32'(n), 32'd49);
        chk("t3_wc", wc(1), 32'd1);
        chk("t3_drained", 32'(q[1].size()), 32'd0);

        // A: reset during bit 5 aborts the frame.
        send(0, 12'h6B3);
        step();
        in_valid[0] = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        q[0].delete();
        step();
        reset = 1'b0;
        chk("t4_ready", 32'(in_ready[0]), 32'd1);
        chk("t4_sdo", 32'(sdo[0]), 32'd0);
        chk("t4_sframe", 32'(sframe[0]), 32'd0);
        chk("t4_busy", 32'(busy[0]), 32'd0);
        chk("t4_wc", wc(0), 32'd0);
        send(0, 12'h5A7);
        step();
        in_valid[0] = 1'b0;
        wait_ready(0, n);
        chk("t4_period", 32'(n), 32'd16);
        chk("t4_wc_after", wc(0), 32'd1);

        // Reset together with in_valid: nothing accepted.
        reset       = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 12'hABC;
        step();
        reset       = 1'b0;
        in_valid[0] = 1'b0;
        chk("rv_busy", 32'(busy[0]), 32'd0);
        chk("rv_ready", 32'(in_ready[0]), 32'd1);
        chk("rv_wc", wc(0), 32'd0);
        step();
        chk("rv_sframe", 32'(sframe[0]), 32'd0);
        chk("rv_busy2", 32'(busy[0]), 32'd0);

        // 4-bit counter wraps after 16 frames.
        exp_wc = 4'd0;
        for (int i = 0; i < 16; i++) begin
            chk("t5_ready", 32'(in_ready[2]), 32'd1);
            send(2, 12'(i * 37 + 5));
            step();
            in_valid[2] = 1'b0;
            wait_ready(2, n);
            exp_wc = exp_wc + 4'd1;
            chk("t5_period", 32'(n), 32'd16);
            chk($sformatf("t5_wc%0d", i), wc(2), 32'(exp_wc));
        end

        step();
        for (int d = 0; d < 3; d++)
            chk($sformatf("drained%0d", d), 32'(q[d].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
